// File: rtl/cam_mon_pkg.sv
// Shared helpers and default sizing for the multi-channel camera frame monitor.
package cam_mon_pkg;

  localparam int unsigned DEF_CLK_HZ      = 50_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC = 5_000_000;

  // Counter width for a given modulus; a modulus of 1 still needs one bit.
  function automatic int clog2_min1(input int unsigned modulus);
    return (modulus <= 1) ? 1 : $clog2(modulus);
  endfunction

  localparam int WIN_W_DEF  = clog2_min1(DEF_CLK_HZ);
  localparam int IDLE_W_DEF = clog2_min1(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/cam_frame_monitor_ch.sv
// One camera channel: vsync synchroniser, edge detect, tick divider,
// per-window frame accumulator and lost-signal timeout.
module cam_frame_monitor_ch
  import cam_mon_pkg::*;
#(
  parameter int TICK        = 30,
  parameter int FPS_W       = 8,
  parameter int TIMEOUT_CYC = 5_000_000,
  parameter int EDGE_FALL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync_i,
  input  logic             win_end_i,
  output logic             tick_o,
  output logic             lost_o,
  output logic [FPS_W-1:0] fps_o
);

  localparam int DIV_W  = clog2_min1(TICK);
  localparam int IDLE_W = clog2_min1(TIMEOUT_CYC);

  logic              s1_q, s2_q, s3_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [FPS_W-1:0]  acc_q, acc_d, acc_plus;
  logic [FPS_W-1:0]  fps_q, fps_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              lost_q, lost_d;
  logic              frame_edge;

  assign frame_edge = (EDGE_FALL != 0) ? (~s2_q & s3_q) : (s2_q & ~s3_q);

  // Accumulator plus this cycle's edge, pinned at all-ones instead of wrapping.
  assign acc_plus = (frame_edge && (acc_q != '1)) ? acc_q + FPS_W'(1) : acc_q;

  always_comb begin
    div_d  = div_q;
    tick_d = tick_q;
    if (frame_edge) begin
      if (div_q == DIV_W'(TICK - 1)) begin
        div_d  = '0;
        tick_d = ~tick_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    fps_d = fps_q;
    acc_d = acc_plus;
    if (win_end_i) begin
      fps_d = acc_plus;
      acc_d = '0;
    end

    idle_d = idle_q;
    lost_d = lost_q;
    if (frame_edge) begin
      idle_d = '0;
      lost_d = 1'b0;
    end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
      lost_d = 1'b1;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      div_q  <= '0;
      tick_q <= 1'b0;
      acc_q  <= '0;
      fps_q  <= '0;
      idle_q <= '0;
      lost_q <= 1'b0;
    end else begin
      s1_q   <= vsync_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      div_q  <= div_d;
      tick_q <= tick_d;
      acc_q  <= acc_d;
      fps_q  <= fps_d;
      idle_q <= idle_d;
      lost_q <= lost_d;
    end
  end

  assign tick_o = tick_q;
  assign lost_o = lost_q;
  assign fps_o  = fps_q;

endmodule

// File: rtl/cam_frame_monitor.sv
// Multi-channel camera vsync monitor: shared one-second window plus
// independent per-channel tick, fps and lost-signal outputs.
module cam_frame_monitor
  import cam_mon_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int TICK        = 30,
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int FPS_W       = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int EDGE_FALL   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       vsync,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       lost,
  output logic [N_CH*FPS_W-1:0] fps,
  output logic                  fps_valid
);

  localparam int WIN_W = clog2_min1(CLK_HZ);

  logic [WIN_W-1:0] win_q, win_d;
  logic             win_end;
  logic             fps_valid_q;

  assign win_end = (win_q == WIN_W'(CLK_HZ - 1));
  assign win_d   = win_end ? '0 : win_q + WIN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= '0;
      fps_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      fps_valid_q <= win_end;
    end
  end

  assign fps_valid = fps_valid_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    cam_frame_monitor_ch #(
      .TICK        (TICK),
      .FPS_W       (FPS_W),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .EDGE_FALL   (EDGE_FALL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .vsync_i   (vsync[gi]),
      .win_end_i (win_end),
      .tick_o    (tick[gi]),
      .lost_o    (lost[gi]),
      .fps_o     (fps[gi*FPS_W +: FPS_W])
    );
  end

endmodule

// File: tb/tb_cam_frame_monitor.sv
// Bench for cam_frame_monitor: rising- and falling-edge instances share stimulus
// and are compared every cycle against an event-level reference model.
module tb_cam_frame_monitor;

  localparam int N_CH = 2, TICK = 3, CLK_HZ = 1000, FPS_W = 4, TIMEOUT = 100;
  localparam int SAT = (1 << FPS_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       vsync = '0;
  logic [N_CH-1:0]       tick_r, lost_r, tick_f, lost_f;
  logic [N_CH*FPS_W-1:0] fps_r, fps_f;
  logic                  valid_r, valid_f;

  always #5 clk = ~clk;

  cam_frame_monitor #(.N_CH(N_CH), .TICK(TICK), .CLK_HZ(CLK_HZ), .FPS_W(FPS_W),
                      .TIMEOUT_CYC(TIMEOUT), .EDGE_FALL(0)) dut_r (
    .clk(clk), .rst(rst), .vsync(vsync), .tick(tick_r), .lost(lost_r),
    .fps(fps_r), .fps_valid(valid_r));

  cam_frame_monitor #(.N_CH(N_CH), .TICK(TICK), .CLK_HZ(CLK_HZ), .FPS_W(FPS_W),
                      .TIMEOUT_CYC(TIMEOUT), .EDGE_FALL(1)) dut_f (
    .clk(clk), .rst(rst), .vsync(vsync), .tick(tick_f), .lost(lost_f),
    .fps(fps_f), .fps_valid(valid_f));

  int checks = 0;
  int fails  = 0;

  // Reference model: k = clock edges since reset release; a qualifying vsync
  // change captured at edge k takes effect on the outputs at edge k+2.
  int unsigned k;
  bit          pv    [2][N_CH];
  int unsigned ecnt  [2][N_CH];
  int unsigned last_e[2][N_CH];
  int unsigned wcnt  [2][N_CH];
  int unsigned fpsm  [2][N_CH];
  int unsigned pend  [2][N_CH][$];
  bit          valid_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    valid_m = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < N_CH; c++) begin
        pv[p][c] = 1'b0; ecnt[p][c] = 0; last_e[p][c] = 0;
        wcnt[p][c] = 0; fpsm[p][c] = 0; pend[p][c].delete();
      end
  endtask

  task automatic model_edge(input logic [N_CH-1:0] v);
    k++;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < N_CH; c++) begin
        bit hit;
        hit = (p == 1) ? (pv[p][c] && !v[c]) : (!pv[p][c] && v[c]);
        if (hit) pend[p][c].push_back(k + 2);
        pv[p][c] = v[c];
        if (pend[p][c].size() > 0 && pend[p][c][0] == k) begin
          void'(pend[p][c].pop_front());
          ecnt[p][c]++;
          last_e[p][c] = k;
          if (wcnt[p][c] < SAT) wcnt[p][c]++;
        end
      end
    valid_m = (k % CLK_HZ) == 0;
    if (valid_m)
      for (int p = 0; p < 2; p++)
        for (int c = 0; c < N_CH; c++) begin
          fpsm[p][c] = wcnt[p][c];
          wcnt[p][c] = 0;
        end
  endtask

  task automatic compare_all();
    for (int p = 0; p < 2; p++) begin
      logic [N_CH-1:0]       et, el;
      logic [N_CH*FPS_W-1:0] ef;
      for (int c = 0; c < N_CH; c++) begin
        et[c] = ((ecnt[p][c] / TICK) % 2) == 1;
        el[c] = (k - last_e[p][c]) >= TIMEOUT;
        ef[c*FPS_W +: FPS_W] = FPS_W'(fpsm[p][c]);
      end
      chk(p ? "tick_f" : "tick_r", 32'(p ? tick_f : tick_r), 32'(et));
      chk(p ? "lost_f" : "lost_r", 32'(p ? lost_f : lost_r), 32'(el));
      chk(p ? "fps_f" : "fps_r", 32'(p ? fps_f : fps_r), 32'(ef));
      chk(p ? "valid_f" : "valid_r", 32'(p ? valid_f : valid_r), 32'(valid_m));
    end
  endtask

  task automatic cyc(input logic [N_CH-1:0] v);
    vsync = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_tick", 32'({tick_r, tick_f}), 32'd0);
    chk("rst_lost", 32'({lost_r, lost_f}), 32'd0);
    chk("rst_fps", 32'({fps_r, fps_f}), 32'd0);
    chk("rst_valid", 32'({valid_r, valid_f}), 32'd0);
    model_reset();
    rst = 1'b0;
  endtask

  // Regular pulses: 1/3 of each period high; ch0 gets n0 pulses, ch1 gets n1.
  task automatic run_pulses(input int n_cyc, input int n0, input int n1, input int per);
    for (int t = 0; t < n_cyc; t++) begin
      logic [N_CH-1:0] v;
      v[0] = (t / per < n0) && (t % per < per / 3);
      v[1] = (t / per < n1) && (t % per < per / 3);
      cyc(v);
    end
  endtask

  task automatic run_random(input int n_cyc, input int dens0, input int dens1);
    logic [N_CH-1:0] v = vsync;
    for (int t = 0; t < n_cyc; t++) begin
      if ($urandom_range(99) < dens0) v[0] = ~v[0];
      if ($urandom_range(99) < dens1) v[1] = ~v[1];
      cyc(v);
    end
  endtask

  initial begin
    model_reset();

    // Tick divider: 7 rising pulses on ch0.
    do_reset();
    run_pulses(300, 7, 0, 30);
    chk("tick_after7", 32'(tick_r), 32'd0);

    // First window: 12/5 pulses, valid exactly at k=1000, then an empty window.
    do_reset();
    run_pulses(999, 12, 5, 60);
    chk("valid_before", 32'(valid_r), 32'd0);
    cyc('0);
    chk("valid_at_1000", 32'(valid_r), 32'd1);
    chk("fps0_12", 32'(fps_r[3:0]), 32'd12);
    chk("fps1_5", 32'(fps_r[7:4]), 32'd5);
    run_pulses(1000, 0, 0, 30);
    chk("fps_empty", 32'(fps_r), 32'd0);

    // Dense random activity saturates ch0.
    do_reset();
    run_random(1000, 50, 8);
    chk("fps0_sat", 32'(fps_r[3:0]), 32'(SAT));

    // Rising edge landing on the win_end cycle belongs to the closing window.
    do_reset();
    run_pulses(997, 0, 0, 30);
    for (int t = 0; t < 10; t++) cyc(2'b01);
    chk("edge_on_winend", 32'(fps_r[3:0]), 32'd1);
    run_pulses(993, 0, 0, 30);
    chk("next_window_rise", 32'(fps_r[3:0]), 32'd0);
    chk("next_window_fall", 32'(fps_f[3:0]), 32'd1);

    // Lost timeout from reset, then a ch1 pulse clears only lost[1].
    do_reset();
    run_pulses(99, 0, 0, 30);
    chk("lost_at_99", 32'(lost_r), 32'd0);
    cyc('0);
    chk("lost_at_100", 32'(lost_r), 32'd3);
    cyc(2'b10);
    cyc(2'b10);
    cyc(2'b10);
    chk("lost_cleared", 32'(lost_r), 32'd1);
    run_pulses(20, 0, 0, 30);

    // Reset in mid-window, then random traffic across a full window.
    run_random(437, 10, 20);
    do_reset();
    run_random(1200, 6, 3);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout k=%0d observed=running expected=finished", k);
    $fatal(1, "bench timeout");
  end

endmodule
